// File: rtl/fir_pkg.sv
// +-------------------------------------------------------------------------+
// | fir_pkg : shared types and helpers for the time-multiplexed FIR slice   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_DEF_COEF = 1;

  // Wide enough that NTAPS full-scale products never wrap.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_delay_line.sv
// +-------------------------------------------------------------------------+
// | fir_delay_line : NTAPS x DW circular sample buffer, write-at-head,      |
// |                  read port addressed by tap offset from the head        |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module fir_delay_line #(
  parameter int NTAPS = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(NTAPS)-1:0] rd_tap,
  output logic [DW-1:0]            rd_data
);

  localparam int AW = $clog2(NTAPS);
  localparam logic [AW:0]   c_NTAPS = (AW+1)'(NTAPS);
  localparam logic [AW-1:0] c_LAST  = AW'(NTAPS - 1);

  logic [DW-1:0] r_line [NTAPS];
  logic [AW-1:0] r_head;
  logic [AW-1:0] w_head_next;
  logic [AW-1:0] w_rd_idx;

  assign w_head_next = (r_head == c_LAST) ? '0 : r_head + 1'b1;

  // (head - tap) mod NTAPS without relying on NTAPS being a power of two.
  assign w_rd_idx = AW'((r_head >= rd_tap) ? ({1'b0, r_head} - {1'b0, rd_tap})
                                           : ({1'b0, r_head} + c_NTAPS - {1'b0, rd_tap}));

  assign rd_data = r_line[w_rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= c_LAST;
      for (int i = 0; i < NTAPS; i++) begin
        r_line[i] <= '0;
      end
    end else if (wr_en) begin
      r_head              <= w_head_next;
      r_line[w_head_next] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_mac_ctrl.sv
// +-------------------------------------------------------------------------+
// | fir_mac_ctrl : FIR controller sharing one MAC across all taps, with     |
// |                coefficient register file and saturated output           |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS = 4,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            x_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OW-1:0]            y_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     coef_ready
);

  localparam int AW     = $clog2(NTAPS);
  localparam int c_ACCW = acc_width(DW, CW, NTAPS);
  localparam logic [AW-1:0] c_LAST = AW'(NTAPS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_coef [NTAPS];
  logic [AW-1:0]      r_tap;
  logic [c_ACCW-1:0]  r_acc;
  logic [OW-1:0]      r_y;

  logic               w_accept;
  logic               w_coef_wr;
  logic               w_last;
  logic               w_addr_ok;
  logic [DW-1:0]      w_sample;
  logic [DW+CW-1:0]   w_prod;
  logic [c_ACCW-1:0]  w_acc_next;
  logic [OW-1:0]      w_y_sat;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_line (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_accept),
    .wr_data (x_in),
    .rd_tap  (r_tap),
    .rd_data (w_sample)
  );

  // Every address is a real tap when NTAPS fills the address space.
  if (NTAPS == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_range
    assign w_addr_ok = ({1'b0, coef_addr} < (AW+1)'(NTAPS));
  end

  assign w_prod     = r_coef[r_tap] * w_sample;
  assign w_acc_next = r_acc + {{(c_ACCW-DW-CW){1'b0}}, w_prod};

  if (c_ACCW > OW) begin : g_sat
    assign w_y_sat = (|w_acc_next[c_ACCW-1:OW]) ? '1 : w_acc_next[OW-1:0];
  end else begin : g_nosat
    assign w_y_sat = OW'(w_acc_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // in_ready is the only output with a combinational input dependency (coef_we).
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_coef_wr    = 1'b0;
    w_last       = 1'b0;
    in_ready     = 1'b0;
    coef_ready   = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        coef_ready = 1'b1;
        in_ready   = !coef_we;
        w_coef_wr  = coef_we && w_addr_ok;
        w_accept   = in_valid && !coef_we;
        if (w_accept) begin
          w_state_next = MAC;
        end
      end
      MAC: begin
        w_last = (r_tap == c_LAST);
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= CW'(c_DEF_COEF);
      end
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tap <= '0;
      r_acc <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_tap <= '0;
      r_acc <= '0;
    end else if (r_state == MAC) begin
      r_acc <= w_acc_next;
      if (w_last) begin
        r_y <= w_y_sat;
      end else begin
        r_tap <= r_tap + 1'b1;
      end
    end
  end

  assign y_out = r_y;

endmodule

`default_nettype wire
